// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and types for the HD44780-compatible bus responder.
//  - Character and DDRAM address-map constants (line bases, line ends, visible length).
//  - Instruction bit masks used by the command decoder.
//  - The responder FSM state type.
package lcd_pkg;

    localparam logic [7:0] LCD_SPACE  = 8'h20;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam int         LINE_LEN   = 16;
    localparam logic [6:0] LINE1_END  = 7'h27;
    localparam logic [6:0] LINE2_END  = 7'h67;

    // The highest set bit of an instruction selects the command.
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_ENTRY   = 8'h04;
    localparam logic [7:0] CMD_DISPCTL = 8'h08;
    localparam logic [7:0] CMD_OTHER   = 8'h70;  // shift / function set / CGRAM address
    localparam logic [7:0] CMD_DDRAM   = 8'h80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        BUSY  = 2'd2
    } lcd_state_e;

endpackage

// File: rtl/lcd_addr_map.sv
// lcd_addr_map: DDRAM address helper shared by the write and read paths.
//  addr      in  7  DDRAM address counter value
//  inc       in  1  entry-mode I/D bit (1 = increment)
//  valid     out 1  address is one of the 32 visible cells
//  idx       out 5  shadow index (0-15 line 1, 16-31 line 2)
//  next_addr out 7  address after one step, wrapping 0x27<->0x40 and 0x67<->0x00
module lcd_addr_map
    import lcd_pkg::*;
(
    input  logic [6:0] addr,
    input  logic       inc,
    output logic       valid,
    output logic [4:0] idx,
    output logic [6:0] next_addr
);

    // Visible-cell decode and next-address computation.
    always_comb begin
        valid     = 1'b0;
        idx       = 5'd0;
        next_addr = addr;
        if (addr < 7'(LINE_LEN)) begin
            valid = 1'b1;
            idx   = {1'b0, addr[3:0]};
        end else if ((addr >= LINE2_BASE) && (addr < (LINE2_BASE + 7'(LINE_LEN)))) begin
            valid = 1'b1;
            idx   = {1'b1, addr[3:0]};
        end else begin
            valid = 1'b0;
            idx   = 5'd0;
        end
        if (inc) begin
            if (addr == LINE1_END) begin
                next_addr = LINE2_BASE;
            end else if (addr == LINE2_END) begin
                next_addr = 7'h00;
            end else begin
                next_addr = addr + 7'd1;
            end
        end else begin
            if (addr == 7'h00) begin
                next_addr = LINE2_END;
            end else if (addr == LINE2_BASE) begin
                next_addr = LINE1_END;
            end else begin
                next_addr = addr - 7'd1;
            end
        end
    end

endmodule

// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder: HD44780-compatible responder for the character-LCD bus.
// Decodes bus writes into a 2x16 DDRAM shadow, an address counter and a busy flag.
// Optional macro LCD_RESP_READ_EN enables status/data reads on the bus.
// Ports:
//  iCLK, iRST            clock, synchronous active-high reset
//  iLCD_EN/RS/RW/DATA    asynchronous LCD bus from the initiator
//  oLCD_DATA, oLCD_DATA_OE  read data and its drive enable
//  iRD_IDX, oRD_CHAR     host shadow read port (1-cycle latency)
//  oADDR, oBUSY, oDISP_ON, oOVERRUN  address counter, busy, display-on, dropped-write pulse
module lcd_bus_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_CYCLES  = 2000,
    parameter int CLEAR_CYCLES = 82000
)(
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iLCD_EN,
    input  logic       iLCD_RS,
    input  logic       iLCD_RW,
    input  logic [7:0] iLCD_DATA,
    output logic [7:0] oLCD_DATA,
    output logic       oLCD_DATA_OE,
    input  logic [4:0] iRD_IDX,
    output logic [7:0] oRD_CHAR,
    output logic [6:0] oADDR,
    output logic       oBUSY,
    output logic       oDISP_ON,
    output logic       oOVERRUN
);

    localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_BUSY  = CNT_W'(BUSY_CYCLES);
    localparam logic [CNT_W-1:0] CNT_HOME  = CNT_W'(CLEAR_CYCLES);
    // The 32 fill cycles of CLEAR count toward the total clear busy time.
    localparam logic [CNT_W-1:0] CNT_CLEAR = CNT_W'(CLEAR_CYCLES - 32);

    logic             en_s1_r, en_s2_r, en_d_r;
    logic             rs_s1_r, rs_s2_r, rw_s1_r, rw_s2_r;
    logic [7:0]       data_s1_r, data_s2_r;
    logic             cap_rs_r, cap_rw_r;
    logic [7:0]       cap_data_r;
    logic             stb_r;

    lcd_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [4:0]       clr_idx_r;
    logic [6:0]       addr_r;
    logic             id_r;
    logic             busy_r;
    logic             disp_on_r;
    logic             overrun_r;
    logic [7:0]       rd_char_r;
    logic [7:0]       shadow_r [32];

    logic             map_valid_s;
    logic [4:0]       map_idx_s;
    logic [6:0]       map_next_s;
    logic             wr_stb_s, accept_s, rd_step_s;
    logic             sh_we_s;
    logic [4:0]       sh_widx_s;
    logic [7:0]       sh_wdata_s;

    lcd_addr_map u_addr_map (
        .addr      (addr_r),
        .inc       (id_r),
        .valid     (map_valid_s),
        .idx       (map_idx_s),
        .next_addr (map_next_s)
    );

    // Bus synchronizers, transaction capture while EN is high, registered falling-edge strobe.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            en_s1_r    <= 1'b0;
            en_s2_r    <= 1'b0;
            en_d_r     <= 1'b0;
            rs_s1_r    <= 1'b0;
            rs_s2_r    <= 1'b0;
            rw_s1_r    <= 1'b0;
            rw_s2_r    <= 1'b0;
            data_s1_r  <= 8'h00;
            data_s2_r  <= 8'h00;
            cap_rs_r   <= 1'b0;
            cap_rw_r   <= 1'b0;
            cap_data_r <= 8'h00;
            stb_r      <= 1'b0;
        end else begin
            en_s1_r   <= iLCD_EN;
            en_s2_r   <= en_s1_r;
            en_d_r    <= en_s2_r;
            rs_s1_r   <= iLCD_RS;
            rs_s2_r   <= rs_s1_r;
            rw_s1_r   <= iLCD_RW;
            rw_s2_r   <= rw_s1_r;
            data_s1_r <= iLCD_DATA;
            data_s2_r <= data_s1_r;
            stb_r     <= en_d_r & ~en_s2_r;
            if (en_s2_r) begin
                cap_rs_r   <= rs_s2_r;
                cap_rw_r   <= rw_s2_r;
                cap_data_r <= data_s2_r;
            end
        end
    end

    // Write acceptance and shadow write-port selection.
    always_comb begin
        wr_stb_s   = stb_r & ~cap_rw_r;
        accept_s   = wr_stb_s & (state_r == IDLE);
        sh_we_s    = 1'b0;
        sh_widx_s  = 5'd0;
        sh_wdata_s = LCD_SPACE;
        if (iRST) begin
            sh_we_s = 1'b0;
        end else if (state_r == CLEAR) begin
            sh_we_s    = 1'b1;
            sh_widx_s  = clr_idx_r;
            sh_wdata_s = LCD_SPACE;
        end else if (accept_s && cap_rs_r && map_valid_s) begin
            sh_we_s    = 1'b1;
            sh_widx_s  = map_idx_s;
            sh_wdata_s = cap_data_r;
        end else begin
            sh_we_s = 1'b0;
        end
    end

    // Responder FSM: command/data decode, clear fill, busy timing and overrun pulse.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_r   <= CLEAR;
            busy_r    <= 1'b1;
            cnt_r     <= {CNT_W{1'b0}};
            clr_idx_r <= 5'd0;
            addr_r    <= 7'h00;
            id_r      <= 1'b1;
            disp_on_r <= 1'b0;
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= wr_stb_s & (state_r != IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        busy_r  <= 1'b1;
                        state_r <= BUSY;
                        cnt_r   <= CNT_BUSY;
                        if (cap_rs_r) begin
                            addr_r <= map_next_s;
                        end else if ((cap_data_r & CMD_DDRAM) != 8'h00) begin
                            addr_r <= cap_data_r[6:0];
                        end else if ((cap_data_r & CMD_OTHER) != 8'h00) begin
                            addr_r <= addr_r;
                        end else if ((cap_data_r & CMD_DISPCTL) != 8'h00) begin
                            disp_on_r <= cap_data_r[2];
                        end else if ((cap_data_r & CMD_ENTRY) != 8'h00) begin
                            id_r <= cap_data_r[1];
                        end else if ((cap_data_r & CMD_HOME) != 8'h00) begin
                            addr_r <= 7'h00;
                            cnt_r  <= CNT_HOME;
                        end else if ((cap_data_r & CMD_CLEAR) != 8'h00) begin
                            addr_r    <= 7'h00;
                            id_r      <= 1'b1;
                            state_r   <= CLEAR;
                            clr_idx_r <= 5'd0;
                        end else begin
                            addr_r <= addr_r;
                        end
                    end
                end
                CLEAR: begin
                    clr_idx_r <= clr_idx_r + 5'd1;
                    if (clr_idx_r == 5'd31) begin
                        if (CNT_CLEAR == {CNT_W{1'b0}}) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= BUSY;
                            cnt_r   <= CNT_CLEAR;
                        end
                    end
                end
                BUSY: begin
                    if (cnt_r <= CNT_W'(1)) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
            // Data reads step the address even while busy; never coincides with a write.
            if (rd_step_s) begin
                addr_r <= map_next_s;
            end
        end
    end

    // Shadow DDRAM storage; contents are initialised by the CLEAR fill after reset.
    always_ff @(posedge iCLK) begin
        if (sh_we_s) begin
            shadow_r[sh_widx_s] <= sh_wdata_s;
        end
    end

    // Host read port.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            rd_char_r <= LCD_SPACE;
        end else begin
            rd_char_r <= shadow_r[iRD_IDX];
        end
    end

`ifdef LCD_RESP_READ_EN
    logic [7:0] bus_char_s;
    logic [7:0] bus_rd_r;
    logic       bus_oe_r;

    // Character at the address counter, spaces for invisible addresses.
    always_comb begin
        if (map_valid_s) begin
            bus_char_s = shadow_r[map_idx_s];
        end else begin
            bus_char_s = LCD_SPACE;
        end
    end

    assign rd_step_s = stb_r & cap_rw_r & cap_rs_r;

    // Bus read data: status (busy + address) or character while a read is enabled.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            bus_oe_r <= 1'b0;
            bus_rd_r <= 8'h00;
        end else if (en_s2_r && rw_s2_r) begin
            bus_oe_r <= 1'b1;
            bus_rd_r <= rs_s2_r ? bus_char_s : {busy_r, addr_r};
        end else begin
            bus_oe_r <= 1'b0;
            bus_rd_r <= 8'h00;
        end
    end

    assign oLCD_DATA_OE = bus_oe_r;
    assign oLCD_DATA    = bus_rd_r;
`else
    assign rd_step_s    = 1'b0;
    assign oLCD_DATA_OE = 1'b0;
    assign oLCD_DATA    = 8'h00;
`endif

    assign oRD_CHAR = rd_char_r;
    assign oADDR    = addr_r;
    assign oBUSY    = busy_r;
    assign oDISP_ON = disp_on_r;
    assign oOVERRUN = overrun_r;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Self-checking bench for lcd_bus_responder (BUSY_CYCLES=20, CLEAR_CYCLES=100).
// Table-driven write vectors plus hand sequences for latency, overrun and busy boundary.
module tb_lcd_bus_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_wdata;
    logic [7:0] lcd_rdata;
    logic       lcd_oe;
    logic [4:0] rd_idx;
    logic [7:0] rd_char;
    logic [6:0] addr;
    logic       busy, disp_on, overrun;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int ov_cnt   = 0;

    always #5 clk = ~clk;

    lcd_bus_responder #(.BUSY_CYCLES(20), .CLEAR_CYCLES(100)) dut (
        .iCLK(clk), .iRST(rst), .iLCD_EN(lcd_en), .iLCD_RS(lcd_rs), .iLCD_RW(lcd_rw),
        .iLCD_DATA(lcd_wdata), .oLCD_DATA(lcd_rdata), .oLCD_DATA_OE(lcd_oe),
        .iRD_IDX(rd_idx), .oRD_CHAR(rd_char), .oADDR(addr), .oBUSY(busy),
        .oDISP_ON(disp_on), .oOVERRUN(overrun)
    );

    always @(negedge clk) begin
        if (overrun === 1'b1) ov_cnt++;
    end

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         wait_cyc;
        logic [6:0] exp_addr;
        logic [4:0] idx;
        logic [7:0] exp_char;
        logic       exp_disp;
    } vec_t;

    vec_t vecs [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Write transaction: EN high for 'hold' cycles, returns just after the effect edge.
    task automatic wr(input logic rs, input logic [7:0] d, input int hold);
        lcd_rs = rs; lcd_rw = 1'b0; lcd_wdata = d; lcd_en = 1'b1;
        repeat (hold) @(posedge clk);
        #1 lcd_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic rd_shadow(input logic [4:0] idx, output logic [7:0] c);
        rd_idx = idx;
        @(posedge clk);
        #1 c = rd_char;
    endtask

    initial begin
        logic [7:0] c;
        int fall;
        int ov_base;

        rst = 1'b1; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_wdata = 8'h00; rd_idx = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 1);
        check("reset_addr", addr, 0);
        check("reset_rd_char", rd_char, 8'h20);
        check("reset_disp", disp_on, 0);
        check("reset_overrun", overrun, 0);
        check("reset_oe", lcd_oe, 0);
        check("reset_rdata", lcd_rdata, 0);

        rst = 1'b0;
        fall = -1;
        for (int k = 1; k <= 120; k++) begin
            @(posedge clk);
            #1;
            if (!busy && fall < 0) fall = k;
        end
        check("busy_after_reset_cycles", fall, 100);
        for (int i = 0; i < 32; i++) begin
            rd_shadow(5'(i), c);
            check("shadow_cleared", c, 8'h20);
        end
        check("addr_after_reset", addr, 0);

        // Strobe latency and busy duration on the first write (cmd 8'h80).
        lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_wdata = 8'h80; lcd_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 lcd_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("latency_edge2_not_busy", busy, 0);
        @(posedge clk);
        #1 check("latency_edge3_busy", busy, 1);
        repeat (19) @(posedge clk);
        #1 check("busy_last_cycle", busy, 1);
        @(posedge clk);
        #1 check("busy_released", busy, 0);
        repeat (3) @(posedge clk);

        vecs[0]  = '{1'b1, 8'h41, 25,  7'h01, 5'd0,  8'h41, 1'b0};
        vecs[1]  = '{1'b1, 8'h42, 25,  7'h02, 5'd1,  8'h42, 1'b0};
        vecs[2]  = '{1'b0, 8'hCF, 25,  7'h4F, 5'd31, 8'h20, 1'b0};
        vecs[3]  = '{1'b1, 8'h58, 25,  7'h50, 5'd31, 8'h58, 1'b0};
        vecs[4]  = '{1'b1, 8'h59, 25,  7'h51, 5'd30, 8'h20, 1'b0};
        vecs[5]  = '{1'b0, 8'h04, 25,  7'h51, 5'd0,  8'h41, 1'b0};
        vecs[6]  = '{1'b0, 8'h80, 25,  7'h00, 5'd1,  8'h42, 1'b0};
        vecs[7]  = '{1'b1, 8'h5A, 25,  7'h67, 5'd0,  8'h5A, 1'b0};
        vecs[8]  = '{1'b0, 8'h06, 25,  7'h67, 5'd0,  8'h5A, 1'b0};
        vecs[9]  = '{1'b1, 8'h31, 25,  7'h00, 5'd16, 8'h20, 1'b0};
        vecs[10] = '{1'b0, 8'hA7, 25,  7'h27, 5'd16, 8'h20, 1'b0};
        vecs[11] = '{1'b1, 8'h33, 25,  7'h40, 5'd16, 8'h20, 1'b0};
        vecs[12] = '{1'b1, 8'h34, 25,  7'h41, 5'd16, 8'h34, 1'b0};
        vecs[13] = '{1'b0, 8'h0C, 25,  7'h41, 5'd16, 8'h34, 1'b1};
        vecs[14] = '{1'b0, 8'h02, 105, 7'h00, 5'd16, 8'h34, 1'b1};
        vecs[15] = '{1'b0, 8'h3B, 25,  7'h00, 5'd0,  8'h5A, 1'b1};
        vecs[16] = '{1'b0, 8'h08, 25,  7'h00, 5'd0,  8'h5A, 1'b0};
        vecs[17] = '{1'b0, 8'h01, 105, 7'h00, 5'd0,  8'h20, 1'b0};
        vecs[18] = '{1'b1, 8'h44, 25,  7'h01, 5'd0,  8'h44, 1'b0};

        for (int v = 0; v < 19; v++) begin
            wr(vecs[v].rs, vecs[v].data, 3);
            check($sformatf("vec%0d_busy_rise", v), busy, 1);
            repeat (vecs[v].wait_cyc) @(posedge clk);
            #1;
            check($sformatf("vec%0d_busy_done", v), busy, 0);
            check($sformatf("vec%0d_addr", v), addr, vecs[v].exp_addr);
            check($sformatf("vec%0d_disp", v), disp_on, vecs[v].exp_disp);
            rd_shadow(vecs[v].idx, c);
            check($sformatf("vec%0d_char", v), c, vecs[v].exp_char);
        end

        // Back-to-back data writes: the second is dropped while busy.
        ov_base = ov_cnt;
        wr(1'b1, 8'h51, 3);
        wr(1'b1, 8'h52, 3);
        repeat (25) @(posedge clk);
        #1;
        check("overrun_pulses", ov_cnt - ov_base, 1);
        check("overrun_addr", addr, 7'h02);
        rd_shadow(5'd1, c);
        check("overrun_first_kept", c, 8'h51);
        rd_shadow(5'd2, c);
        check("overrun_second_dropped", c, 8'h20);

        // Strobe landing on the busy counter's final cycle is dropped.
        ov_base = ov_cnt;
        wr(1'b1, 8'h53, 3);
        wr(1'b1, 8'h54, 16);
        repeat (25) @(posedge clk);
        #1;
        check("final_cycle_overrun", ov_cnt - ov_base, 1);
        check("final_cycle_addr", addr, 7'h03);
        rd_shadow(5'd3, c);
        check("final_cycle_dropped", c, 8'h20);

        // One cycle later the strobe is accepted.
        ov_base = ov_cnt;
        wr(1'b1, 8'h55, 3);
        wr(1'b1, 8'h56, 17);
        repeat (25) @(posedge clk);
        #1;
        check("after_busy_no_overrun", ov_cnt - ov_base, 0);
        check("after_busy_addr", addr, 7'h05);
        rd_shadow(5'd4, c);
        check("after_busy_accepted", c, 8'h56);

`ifdef LCD_RESP_READ_EN
        wr(1'b0, 8'h01, 3);
        lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_en = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("status_read_oe", lcd_oe, 1);
        check("status_read_busy_bit", lcd_rdata[7], 1);
        lcd_en = 1'b0;
        repeat (110) @(posedge clk);
        lcd_en = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("status_read_idle", lcd_rdata, 8'h00);
        lcd_en = 1'b0;
        repeat (5) @(posedge clk);
        lcd_rs = 1'b1; lcd_en = 1'b1;
        repeat (5) @(posedge clk);
        #1 check("data_read_char", lcd_rdata, 8'h20);
        lcd_en = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("data_read_addr_step", addr, 7'h01);
        lcd_rw = 1'b0; lcd_rs = 1'b0;
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
